// File: rtl/sketch_counter_update.sv
// sketch_counter_update
//   Last stage of the sketch hash pipeline. Each hash result {row, col} is
//   paired in order with a packet byte count. The matching SRAM counter is
//   then updated with a read-modify-write: counter += bytes. A clear request
//   sweeps zeros over the whole counter array. Clock domain: memclk.
//
//   Optional feature macro: SKETCH_SATURATE_EN
//     defined   - the sum clamps at all-ones, so a counter never wraps
//     undefined - the sum wraps modulo 2**CNT_WIDTH
//
// Ports
//   memclk_i, reset_i            clock, async active-high reset
//   hash_valid_i/hash_data_i/
//   sram_id_i                    hash push (col = hash LSBs, row = id LSBs)
//   byte_valid_i/byte_cnt_i      byte-count push
//   clear_req_i                  pulse: zero every counter
//   mem_req_o/mem_wr_o/
//   mem_addr_o/mem_wdata_o       registered SRAM request, held until mem_gnt_i
//   mem_gnt_i                    request accepted this cycle
//   mem_rvalid_i/mem_rdata_i     read return, latency >= 1
//   busy_o                       FSM active or either queue non-empty
//   drop_cnt_o                   saturating count of overflow drops
//   update_cnt_o                 wrapping count of completed updates
module sketch_counter_update #(
    parameter int HASH_WIDTH  = 32,
    parameter int ID_WIDTH    = 16,
    parameter int BYTE_WIDTH  = 16,
    parameter int ROW_BITS    = 2,
    parameter int COL_BITS    = 16,
    parameter int CNT_WIDTH   = 32,
    parameter int QDEPTH_LOG2 = 2
) (
    input  logic                         memclk_i,
    input  logic                         reset_i,
    input  logic                         hash_valid_i,
    input  logic [HASH_WIDTH-1:0]        hash_data_i,
    input  logic [ID_WIDTH-1:0]          sram_id_i,
    input  logic                         byte_valid_i,
    input  logic [BYTE_WIDTH-1:0]        byte_cnt_i,
    input  logic                         clear_req_i,
    output logic                         mem_req_o,
    output logic                         mem_wr_o,
    output logic [ROW_BITS+COL_BITS-1:0] mem_addr_o,
    output logic [CNT_WIDTH-1:0]         mem_wdata_o,
    input  logic                         mem_gnt_i,
    input  logic                         mem_rvalid_i,
    input  logic [CNT_WIDTH-1:0]         mem_rdata_i,
    output logic                         busy_o,
    output logic [15:0]                  drop_cnt_o,
    output logic [31:0]                  update_cnt_o
);
    localparam int AW = ROW_BITS + COL_BITS;
    localparam int QD = 1 << QDEPTH_LOG2;
    localparam logic [QDEPTH_LOG2:0] QFULL = (QDEPTH_LOG2+1)'(QD);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, CLR} state_e;

    state_e                 state_q;
    logic                   clr_pend_q;
    logic [BYTE_WIDTH-1:0]  bytes_q;
    logic                   mem_req_q, mem_wr_q;
    logic [AW-1:0]          mem_addr_q;
    logic [CNT_WIDTH-1:0]   mem_wdata_q;
    logic [15:0]            drop_q;
    logic [31:0]            upd_q;

    // Queue storage carries no reset; only the pointers and counts matter.
    logic [AW-1:0]          hq_mem_q [QD];
    logic [BYTE_WIDTH-1:0]  bq_mem_q [QD];
    logic [QDEPTH_LOG2-1:0] hq_wp_q, hq_rp_q, bq_wp_q, bq_rp_q;
    logic [QDEPTH_LOG2:0]   hq_cnt_q, bq_cnt_q;

    logic clear_go, pop, hq_full, bq_full, hq_push, bq_push, hq_ovf, bq_ovf;
    logic [AW-1:0]          hq_in;
    logic [CNT_WIDTH:0]     sum_ext;
    logic [CNT_WIDTH-1:0]   sum_d;
    logic                   unused_bits;

    assign hq_in    = {sram_id_i[ROW_BITS-1:0], hash_data_i[COL_BITS-1:0]};
    assign clear_go = clear_req_i || clr_pend_q;
    assign hq_full  = (hq_cnt_q == QFULL);
    assign bq_full  = (bq_cnt_q == QFULL);
    // A pending clear outranks queued pairs, so no pop while one is waiting.
    assign pop      = (state_q == IDLE) && !clear_go && (hq_cnt_q != '0) && (bq_cnt_q != '0);
    // A full queue still accepts a push when its head leaves the same cycle.
    assign hq_push  = hash_valid_i && (!hq_full || pop);
    assign bq_push  = byte_valid_i && (!bq_full || pop);
    assign hq_ovf   = hash_valid_i && !hq_push;
    assign bq_ovf   = byte_valid_i && !bq_push;

    assign sum_ext = {1'b0, mem_rdata_i} + {{(CNT_WIDTH+1-BYTE_WIDTH){1'b0}}, bytes_q};
`ifdef SKETCH_SATURATE_EN
    assign sum_d = sum_ext[CNT_WIDTH] ? '1 : sum_ext[CNT_WIDTH-1:0];
`else
    assign sum_d = sum_ext[CNT_WIDTH-1:0];
`endif
    assign unused_bits = ^{hash_data_i, sram_id_i, sum_ext[CNT_WIDTH]};

    always_ff @(posedge memclk_i) begin
        if (hq_push) hq_mem_q[hq_wp_q] <= hq_in;
        if (bq_push) bq_mem_q[bq_wp_q] <= byte_cnt_i;
    end

    always_ff @(posedge memclk_i or posedge reset_i) begin
        if (reset_i) begin
            hq_wp_q  <= '0; hq_rp_q <= '0; hq_cnt_q <= '0;
            bq_wp_q  <= '0; bq_rp_q <= '0; bq_cnt_q <= '0;
            drop_q   <= '0;
        end else begin
            if (hq_push) hq_wp_q <= hq_wp_q + 1'b1;
            if (bq_push) bq_wp_q <= bq_wp_q + 1'b1;
            if (pop) begin
                hq_rp_q <= hq_rp_q + 1'b1;
                bq_rp_q <= bq_rp_q + 1'b1;
            end
            if (hq_push && !pop)      hq_cnt_q <= hq_cnt_q + 1'b1;
            else if (!hq_push && pop) hq_cnt_q <= hq_cnt_q - 1'b1;
            if (bq_push && !pop)      bq_cnt_q <= bq_cnt_q + 1'b1;
            else if (!bq_push && pop) bq_cnt_q <= bq_cnt_q - 1'b1;
            // Both queues overflowing together still count as one lost packet.
            if ((hq_ovf || bq_ovf) && drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
        end
    end

    always_ff @(posedge memclk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            clr_pend_q  <= 1'b0;
            bytes_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            upd_q       <= '0;
        end else begin
            if (clear_req_i && state_q != IDLE && state_q != CLR) clr_pend_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (clear_go) begin
                        clr_pend_q  <= 1'b0;
                        state_q     <= CLR;
                        mem_req_q   <= 1'b1;
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                    end else if (pop) begin
                        state_q    <= RD_REQ;
                        mem_req_q  <= 1'b1;
                        mem_wr_q   <= 1'b0;
                        mem_addr_q <= hq_mem_q[hq_rp_q];
                        bytes_q    <= bq_mem_q[bq_rp_q];
                    end
                end
                RD_REQ: if (mem_gnt_i) begin
                    mem_req_q <= 1'b0;
                    state_q   <= RD_WAIT;
                end
                RD_WAIT: if (mem_rvalid_i) begin
                    mem_req_q   <= 1'b1;
                    mem_wr_q    <= 1'b1;
                    mem_wdata_q <= sum_d;
                    state_q     <= WR_REQ;
                end
                WR_REQ: if (mem_gnt_i) begin
                    mem_req_q <= 1'b0;
                    mem_wr_q  <= 1'b0;
                    upd_q     <= upd_q + 1'b1;
                    state_q   <= IDLE;
                end
                CLR: begin
                    // The address register doubles as the sweep counter.
                    if (clear_req_i) begin
                        mem_addr_q <= '0;
                    end else if (mem_gnt_i) begin
                        if (mem_addr_q == '1) begin
                            mem_req_q <= 1'b0;
                            mem_wr_q  <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            mem_addr_q <= mem_addr_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_wr_o     = mem_wr_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign busy_o       = (state_q != IDLE) || (hq_cnt_q != '0) || (bq_cnt_q != '0);
    assign drop_cnt_o   = drop_q;
    assign update_cnt_o = upd_q;
endmodule

// File: tb/tb_sketch_counter_update.sv
// Directed bench for sketch_counter_update. It uses COL_BITS=6 so that a
// full clear sweep is 256 writes: address = {row[1:0], col[5:0]}. The SRAM
// model grants at the negedge and returns read data one cycle after the
// grant unless rd_hold is set.
module tb_sketch_counter_update;
    localparam int AW = 8;

`ifdef SKETCH_SATURATE_EN
    localparam logic [31:0] SAT_EXP = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] SAT_EXP = 32'h0000_0010;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        hash_valid = 0, byte_valid = 0, clear_req = 0;
    logic [31:0] hash_data = 0;
    logic [15:0] sram_id = 0, byte_cnt = 0;
    logic        mem_req, mem_wr, mem_gnt = 0, mem_rvalid = 0, busy;
    logic [AW-1:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata = 0, update_cnt;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    sketch_counter_update #(.COL_BITS(6)) dut (
        .memclk_i(clk), .reset_i(rst),
        .hash_valid_i(hash_valid), .hash_data_i(hash_data), .sram_id_i(sram_id),
        .byte_valid_i(byte_valid), .byte_cnt_i(byte_cnt), .clear_req_i(clear_req),
        .mem_req_o(mem_req), .mem_wr_o(mem_wr), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .busy_o(busy), .drop_cnt_o(drop_cnt),
        .update_cnt_o(update_cnt)
    );

    // SRAM model
    logic [31:0]   mem [256] = '{default: 32'h0};
    bit            gnt_en = 1, wr_block = 0, rd_hold = 0, pend_rd = 0;
    logic [31:0]   pend_d = 0;
    logic          g_wr = 0;
    logic [AW-1:0] g_a = 0;
    logic [31:0]   g_d = 0;
    int            wr_cnt = 0;
    logic [31:0]   wlog_a [$];
    logic [31:0]   wlog_d [$];
    int            pre_seq = 0, pre_done = 0;
    logic [AW-1:0] pre_a = 0;
    logic [31:0]   pre_d = 0;

    always @(negedge clk) begin
        mem_rvalid = 1'b0;
        if (pre_seq != pre_done) begin
            mem[pre_a] = pre_d;
            pre_done = pre_seq;
        end
        if (rst) begin
            mem_gnt = 1'b0;
            pend_rd = 0;
        end else begin
            // mem_gnt high here means the handshake completed at the last posedge.
            if (mem_gnt) begin
                if (g_wr) begin
                    mem[g_a] = g_d;
                    wr_cnt++;
                    wlog_a.push_back(32'(g_a));
                    wlog_d.push_back(g_d);
                end else begin
                    pend_rd = 1;
                    pend_d = mem[g_a];
                end
            end
            if (pend_rd && !rd_hold) begin
                mem_rvalid = 1'b1;
                mem_rdata = pend_d;
                pend_rd = 0;
            end
            mem_gnt = gnt_en && mem_req && !(wr_block && mem_wr);
            g_wr = mem_wr; g_a = mem_addr; g_d = mem_wdata;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic preset(input logic [AW-1:0] a, input logic [31:0] d);
        pre_a = a; pre_d = d; pre_seq++;
        repeat (2) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] h, input logic [15:0] id, input logic [15:0] b);
        hash_data = h; sram_id = id; byte_cnt = b;
        hash_valid = 1; byte_valid = 1;
        @(negedge clk);
        hash_valid = 0; byte_valid = 0;
    endtask

    task automatic wait_wr(input int n, input int budget);
        int k = 0;
        while (wr_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("wait_wr", 32'(wr_cnt), 32'(n));
    endtask

    initial begin
        int base, k;
        bit saw;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_wr", 32'(mem_wr), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_upd", update_cnt, 0);
        rst = 0;
        @(negedge clk);

        // single update: row 1, col 0x10 (upper hash/id bits ignored)
        preset(8'h50, 32'd100);
        push(32'hABCD_0010, 16'h0101, 16'd64);
        wait_wr(1, 50);
        chk("t1_addr", wlog_a[0], 32'h50);
        chk("t1_data", wlog_d[0], 32'd164);
        repeat (2) @(negedge clk);
        chk("t1_upd", update_cnt, 1);
        chk("t1_busy", 32'(busy), 0);

        // counter overflow arithmetic
        preset(8'h82, 32'hFFFF_FFF0);
        push(32'h0000_0002, 16'h0002, 16'h0020);
        wait_wr(2, 50);
        chk("t2_addr", wlog_a[1], 32'h82);
        chk("t2_data", wlog_d[1], SAT_EXP);

        // queue overflow while a stalled clear holds the FSM
        gnt_en = 0;
        @(negedge clk);
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        @(negedge clk);
        chk("t3_clr_req", 32'(mem_req), 1);
        for (int i = 0; i < 6; i++) push(32'(i), 16'h0000, 16'(i + 1));
        @(negedge clk);
        chk("t3_drop", 32'(drop_cnt), 2);
        chk("t3_busy", 32'(busy), 1);
        base = wr_cnt;
        gnt_en = 1;
        wait_wr(base + 260, 400);
        repeat (5) @(negedge clk);
        chk("t3_wrcnt", 32'(wr_cnt - base), 260);
        chk("t3_upd", update_cnt, 6);
        for (int i = 0; i < 4; i++) chk("t3_cnt", mem[i], 32'(i + 1));
        chk("t3_drop4", mem[4], 0);
        chk("t3_drop5", mem[5], 0);
        chk("t3_cleared", mem[8'h82], 0);

        // pairing skew: bytes arrive 3 cycles after the hash
        preset(8'hC7, 32'd1000);
        base = wr_cnt;
        hash_data = 32'h7; sram_id = 16'h3; hash_valid = 1;
        @(negedge clk);
        hash_valid = 0;
        saw = mem_req;
        repeat (2) begin
            @(negedge clk);
            saw |= mem_req;
        end
        chk("t4_busy", 32'(busy), 1);
        byte_cnt = 16'h0123; byte_valid = 1;
        @(negedge clk);
        byte_valid = 0;
        chk("t4_noreq", 32'(saw), 0);
        wait_wr(base + 1, 50);
        chk("t4_addr", wlog_a[base], 32'hC7);
        chk("t4_data", wlog_d[base], 32'h50B);
        chk("t4_upd", update_cnt, 7);

        // clear during RD_WAIT: write completes, sweep, then queued pair
        preset(8'h41, 32'd5);
        rd_hold = 1;
        base = wr_cnt;
        push(32'h1, 16'h1, 16'd10);
        push(32'h2, 16'h1, 16'd20);
        k = 0;
        while (!pend_rd && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t5_inwait", 32'(pend_rd), 1);
        clear_req = 1;
        @(negedge clk);
        clear_req = 0;
        repeat (3) @(negedge clk);
        chk("t5_held", 32'(wr_cnt - base), 0);
        rd_hold = 0;
        wait_wr(base + 258, 400);
        repeat (5) @(negedge clk);
        chk("t5_wrcnt", 32'(wr_cnt - base), 258);
        chk("t5_rmw_a", wlog_a[base], 32'h41);
        chk("t5_rmw_d", wlog_d[base], 32'd15);
        chk("t5_clr0_a", wlog_a[base + 1], 0);
        chk("t5_clr0_d", wlog_d[base + 1], 0);
        chk("t5_clrN_a", wlog_a[base + 256], 32'hFF);
        chk("t5_after_a", wlog_a[base + 257], 32'h42);
        chk("t5_after_d", wlog_d[base + 257], 32'd20);
        chk("t5_mem41", mem[8'h41], 0);
        chk("t5_upd", update_cnt, 9);

        // async reset while waiting in WR_REQ
        wr_block = 1;
        base = wr_cnt;
        push(32'h13, 16'h0, 16'd5);
        push(32'h14, 16'h0, 16'd6);
        k = 0;
        while (!(mem_req && mem_wr) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("t6_inwr", 32'(mem_req && mem_wr), 1);
        #2 rst = 1;
        #1;
        chk("t6_req", 32'(mem_req), 0);
        chk("t6_wr", 32'(mem_wr), 0);
        chk("t6_addr", 32'(mem_addr), 0);
        chk("t6_upd", update_cnt, 0);
        chk("t6_drop", 32'(drop_cnt), 0);
        chk("t6_busy", 32'(busy), 0);
        @(negedge clk);
        rst = 0;
        wr_block = 0;
        repeat (6) @(negedge clk);
        chk("t6_idle", 32'(busy), 0);
        chk("t6_nowr", 32'(wr_cnt - base), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
